// File: rtl/gc_apb_fifo_slave.sv
// APB3 completer giving the Cortex-M3 a TX FIFO toward the GameCube controller
// logic, an RX FIFO back from it, a control/status register pair and a level
// interrupt. Zero-wait transfers take effect on the clock edge that raises
// PREADY; DATA reads add one wait state to register and pop the RX head.
module gc_apb_fifo_slave #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);

    localparam logic [1:0]    REG_DATA   = 2'd0;
    localparam logic [1:0]    REG_STATUS = 2'd1;
    localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [31:0]   tx_mem [DEPTH];
    logic [31:0]   rx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [AW:0]   tx_count_reg, rx_count_reg;
    logic          en_reg, irq_en_reg, rx_overflow_reg, rd_wait_reg, irq_reg;
    logic          pready_reg, pslverr_reg;
    logic [31:0]   prdata_reg;

    logic          setup, unmapped, tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_pop, rx_push, tx_push, rx_pop, ctrl_wr, clr, rd_start;
    logic          resp, resp_err;
    logic [31:0]   resp_data, status_word, ctrl_word;
    logic [1:0]    sel_reg;
    logic          unused_paddr;

    assign unused_paddr = ^PADDR[1:0];

    assign setup    = PSEL & ~PENABLE;
    assign sel_reg  = PADDR[3:2];
    assign unmapped = (PADDR[7:4] != 4'd0) | (sel_reg == 2'd3);

    assign tx_empty = (tx_count_reg == '0);
    assign tx_full  = (tx_count_reg == FULL_CNT);
    assign rx_empty = (rx_count_reg == '0);
    assign rx_full  = (rx_count_reg == FULL_CNT);

    assign tx_valid = en_reg & ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_ready = en_reg & ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign tx_data  = tx_empty ? 32'd0 : tx_mem[tx_rd_ptr_reg];

    assign status_word = {8'(tx_count_reg), 8'(rx_count_reg), 12'd0,
                          rx_overflow_reg, rx_full, tx_full, ~rx_empty};
    // CLR always reads back as 0
    assign ctrl_word   = {29'd0, 1'b0, irq_en_reg, en_reg};

    assign PRDATA  = prdata_reg;
    assign PREADY  = pready_reg;
    assign PSLVERR = pslverr_reg;
    assign irq     = irq_reg;

    // Decode the bus: setup phase answers everything except DATA reads, which
    // complete in the following access cycle if PSEL/PENABLE are still held.
    always_comb begin
        tx_push   = 1'b0;
        rx_pop    = 1'b0;
        ctrl_wr   = 1'b0;
        clr       = 1'b0;
        rd_start  = 1'b0;
        resp      = 1'b0;
        resp_err  = 1'b0;
        resp_data = 32'd0;
        if (setup) begin
            if (unmapped) begin
                resp     = 1'b1;
                resp_err = 1'b1;
            end else if (PWRITE) begin
                resp = 1'b1;
                case (sel_reg)
                    REG_DATA: begin
                        // a full TX FIFO still accepts the word if it is popped this cycle
                        if (tx_full & ~tx_pop) resp_err = 1'b1;
                        else                   tx_push  = 1'b1;
                    end
                    REG_STATUS: resp_err = 1'b1;
                    default: begin
                        ctrl_wr = 1'b1;
                        clr     = PWDATA[2];
                    end
                endcase
            end else begin
                case (sel_reg)
                    REG_DATA:   rd_start = 1'b1;
                    REG_STATUS: begin
                        resp      = 1'b1;
                        resp_data = status_word;
                    end
                    default: begin
                        resp      = 1'b1;
                        resp_data = ctrl_word;
                    end
                endcase
            end
        end else if (rd_wait_reg & PSEL & PENABLE) begin
            resp = 1'b1;
            if (rx_empty) begin
                resp_err = 1'b1;
            end else begin
                rx_pop    = 1'b1;
                resp_data = rx_mem[rx_rd_ptr_reg];
            end
        end
    end

    // One-cycle APB response pulse and the DATA-read wait-state flag
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            prdata_reg  <= 32'd0;
            rd_wait_reg <= 1'b0;
        end else begin
            pready_reg  <= resp;
            pslverr_reg <= resp_err;
            prdata_reg  <= resp_data;
            rd_wait_reg <= rd_start;
        end
    end

    // Control bits, sticky RX overflow and the registered interrupt
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            en_reg          <= 1'b0;
            irq_en_reg      <= 1'b0;
            rx_overflow_reg <= 1'b0;
            irq_reg         <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en_reg     <= PWDATA[0];
                irq_en_reg <= PWDATA[1];
            end
            if (clr)                                rx_overflow_reg <= 1'b0;
            else if (rx_valid & en_reg & rx_full)   rx_overflow_reg <= 1'b1;
            irq_reg <= irq_en_reg & (~rx_empty | rx_overflow_reg);
        end
    end

    // TX FIFO pointers and occupancy; CLR overrides a same-cycle pop
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else if (clr) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_count_reg <= tx_count_reg + CNT_ONE;
                2'b01:   tx_count_reg <= tx_count_reg - CNT_ONE;
                default: ;
            endcase
        end
    end

    // RX FIFO pointers and occupancy; CLR overrides a same-cycle push
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else if (clr) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + CNT_ONE;
                2'b01:   rx_count_reg <= rx_count_reg - CNT_ONE;
                default: ;
            endcase
        end
    end

    // FIFO storage; contents need no reset since emptiness is tracked by the counts
    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wr_ptr_reg] <= PWDATA;
        if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_data;
    end

endmodule

// File: tb/tb_gc_apb_fifo_slave.sv
// Directed bench for gc_apb_fifo_slave: inputs change and outputs are sampled
// on the falling edge of PCLK; expected values are written out by hand.
module tb_gc_apb_fifo_slave;

    logic        PCLK, PRESERN, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA, tx_data, rx_data;
    logic        PREADY, PSLVERR, tx_valid, tx_ready, rx_valid, rx_ready, irq;

    int errors = 0;
    int checks = 0;

    gc_apb_fifo_slave #(.DEPTH(8), .AW(3)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int wt);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        wt = 0;
        while (PREADY !== 1'b1 && wt < 8) begin
            @(negedge PCLK);
            wt++;
        end
        check("pready", {31'd0, PREADY}, 32'd1);
        rd = PRDATA;
        er = PSLVERR;
        $display("apb %s addr=%h wdata=%h rdata=%h err=%0d waits=%0d",
                 w ? "wr" : "rd", a, wd, rd, er, wt);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] wd,
                             input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        er;
        int          wt;
        apb(1'b1, a, wd, rd, er, wt);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, "_wait"}, wt, 0);
    endtask

    task automatic apb_read(input logic [7:0] a, input logic [31:0] exp_data,
                            input logic exp_err, input int exp_wt, input string tag);
        logic [31:0] rd;
        logic        er;
        int          wt;
        apb(1'b0, a, 32'd0, rd, er, wt);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, "_wait"}, wt, exp_wt);
    endtask

    // Push into TX while the consumer pops the full FIFO in the same cycle
    task automatic sim_push_pop(input logic [31:0] word, input logic [31:0] exp_head);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = word;
        tx_ready = 1'b1;
        @(negedge PCLK);
        tx_ready = 1'b0; PENABLE = 1'b1;
        check("sim_pready", {31'd0, PREADY}, 32'd1);
        check("sim_err", {31'd0, PSLVERR}, 32'd0);
        check("sim_head", tx_data, exp_head);
        $display("apb wr+pop word=%h head=%h err=%0d", word, tx_data, PSLVERR);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 32'd0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'd0;

        // Reset state
        repeat (3) @(negedge PCLK);
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        PRESERN = 1'b1;

        apb_read(8'h04, 32'h0000_0000, 1'b0, 0, "status0");
        check("irq0", {31'd0, irq}, 32'd0);
        check("tx_valid0", {31'd0, tx_valid}, 32'd0);

        // TX fill, overflow attempt, drain in order
        apb_write(8'h08, 32'h1, 1'b0, "ctrl_en");
        for (int i = 0; i < 8; i++) apb_write(8'h00, 32'hA5A5_0001 + i, 1'b0, "tx_push");
        apb_write(8'h00, 32'hA5A5_0009, 1'b1, "tx_push_full");
        apb_read(8'h04, 32'h0800_0002, 1'b0, 0, "status_txfull");
        @(negedge PCLK);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", {31'd0, tx_valid}, 32'd1);
            check("drain_data", tx_data, 32'hA5A5_0001 + i);
            $display("tx pop data=%h", tx_data);
            @(negedge PCLK);
        end
        check("drain_done", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // RX word, interrupt latency, wait-state DATA read, empty read
        apb_write(8'h08, 32'h3, 1'b0, "ctrl_irq");
        @(negedge PCLK);
        rx_valid = 1'b1; rx_data = 32'h1234_5678;
        @(negedge PCLK);
        rx_valid = 1'b0;
        check("irq_lat1", {31'd0, irq}, 32'd0);
        @(negedge PCLK);
        check("irq_lat2", {31'd0, irq}, 32'd1);
        apb_read(8'h00, 32'h1234_5678, 1'b0, 1, "rx_read");
        check("irq_fall", {31'd0, irq}, 32'd0);
        apb_read(8'h00, 32'h0000_0000, 1'b1, 1, "rx_read_empty");

        // RX fill and overflow, then CLR
        @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1; rx_data = 32'hB000_0000 + i;
            @(negedge PCLK);
        end
        check("rx_full_ready", {31'd0, rx_ready}, 32'd0);
        @(negedge PCLK);
        rx_valid = 1'b0;
        apb_read(8'h04, 32'h0008_000D, 1'b0, 0, "status_rxovf");
        check("irq_ovf", {31'd0, irq}, 32'd1);
        apb_write(8'h08, 32'h7, 1'b0, "ctrl_clr");
        apb_read(8'h04, 32'h0000_0000, 1'b0, 0, "status_clr");
        apb_read(8'h08, 32'h0000_0003, 1'b0, 0, "ctrl_rb");
        check("irq_clr", {31'd0, irq}, 32'd0);

        // Full TX with simultaneous push and pop, across the pointer wrap
        for (int i = 0; i < 8; i++) apb_write(8'h00, 32'hC000_0001 + i, 1'b0, "tx_fill");
        for (int k = 1; k <= 6; k++) sim_push_pop(32'hC000_0008 + k, 32'hC000_0001 + k);
        apb_read(8'h04, 32'h0800_0002, 1'b0, 0, "status_sim");
        @(negedge PCLK);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("wrap_data", tx_data, 32'hC000_0007 + i);
            $display("tx pop data=%h", tx_data);
            @(negedge PCLK);
        end
        check("wrap_done", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Error responses leave state alone
        apb_read(8'h0C, 32'h0, 1'b1, 0, "rd_0c");
        apb_write(8'h0C, 32'hFFFF_FFFF, 1'b1, "wr_0c");
        apb_read(8'h10, 32'h0, 1'b1, 0, "rd_10");
        apb_write(8'h18, 32'h0, 1'b1, "wr_18");
        apb_write(8'h04, 32'hFFFF_FFFF, 1'b1, "wr_status");
        apb_read(8'h08, 32'h0000_0003, 1'b0, 0, "ctrl_keep");
        apb_read(8'h04, 32'h0000_0000, 1'b0, 0, "status_keep");

        // DATA read aborted in its wait state must not pop
        @(negedge PCLK);
        rx_valid = 1'b1; rx_data = 32'hD00D_0001;
        @(negedge PCLK);
        rx_valid = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        @(negedge PCLK);
        check("abort_wait", {31'd0, PREADY}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check("abort_noready", {31'd0, PREADY}, 32'd0);
        $display("apb rd addr=00 aborted in wait state");
        apb_read(8'h04, 32'h0001_0001, 1'b0, 0, "status_abort");
        apb_read(8'h00, 32'hD00D_0001, 1'b0, 1, "rx_after_abort");

        // EN=0 gates the streaming side but not APB access
        apb_write(8'h08, 32'h0, 1'b0, "ctrl_off");
        check("off_rx_ready", {31'd0, rx_ready}, 32'd0);
        apb_write(8'h00, 32'hE000_0001, 1'b0, "tx_push_off");
        check("off_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("off_tx_data", tx_data, 32'hE000_0001);
        apb_read(8'h04, 32'h0100_0000, 1'b0, 0, "status_off");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gc_apb_fifo_slave.md
Name: gc_apb_fifo_slave

Overview:
- APB3 completer in the fabric, driven by the MSS fabric APB master (MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA, returning MSSPRDATA/MSSPREADY/MSSPSLVERR).
- Gives the Cortex-M3 a TX FIFO toward the GameCube controller logic and an RX FIFO back from it.
- Also provides a control register, a status register and a level interrupt toward the MSS GPI.

Parameters:
DEPTH, 8, entries per FIFO; power of two, 2..64
AW, 3, FIFO pointer width = log2(DEPTH)

Ports:
PCLK  in  1  fabric clock (FAB_CLK)
PRESERN  in  1  asynchronous active-low reset (M2F_RESET_N)
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write
PADDR  in  8  byte address; bits [3:2] select the register
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error
tx_data  out  32  head of TX FIFO
tx_valid  out  1  TX FIFO not empty and CTRL.EN=1
tx_ready  in  1  consumer accepts tx_data when tx_valid & tx_ready
rx_data  in  32  producer word
rx_valid  in  1  push rx_data when rx_valid & rx_ready
rx_ready  out  1  RX FIFO not full and CTRL.EN=1
irq  out  1  level interrupt

Behaviour:
- Reset (PRESERN low, asynchronous):
  - All outputs 0: PRDATA, PREADY, PSLVERR, tx_valid, rx_ready, irq. tx_data is 0 because the FIFO is empty.
  - FIFO pointers and counts 0; CTRL = 0.
- APB phases:
  - Setup phase: PSEL=1, PENABLE=0.
  - Access phase: PSEL=1, PENABLE=1. It completes on the cycle PREADY=1.
  - PREADY and PSLVERR are registered and asserted for exactly one cycle, in the completing cycle. PRDATA is valid in that same cycle and 0 otherwise.
- Latency:
  - All writes and all reads except DATA: PREADY is high in the first access cycle (zero wait states).
  - DATA read: one wait state. The RX FIFO head is registered and popped, then PREADY is asserted in the second access cycle.
- Register map, PADDR[3:2] (PADDR[7:4] must be 0, otherwise the access is unmapped):
  - 0x00 DATA:
    - Write pushes PWDATA into the TX FIFO.
    - Read pops the RX FIFO.
  - 0x04 STATUS (read-only):
    - [31:24] tx_count, [23:16] rx_count, zero-extended.
    - [3] rx_overflow (sticky), [2] rx_full, [1] tx_full, [0] rx_not_empty.
  - 0x08 CTRL (RW):
    - [0] EN, [1] IRQ_EN.
    - [2] CLR is write-1, self-clearing and reads 0. A CLR write empties both FIFOs and clears rx_overflow on the completing cycle.
  - 0x0C unmapped.
- PSLVERR=1 on the completing cycle in these cases, with no state change:
  - unmapped address (read or write);
  - write to STATUS;
  - DATA write while the TX FIFO is full (word dropped);
  - DATA read while the RX FIFO is empty (PRDATA = 0, no pop).
- FIFOs:
  - Circular buffers; pointers wrap DEPTH-1 -> 0. Counts are AW+1 bits wide, range 0..DEPTH.
  - A push and a pop in the same cycle leave the count unchanged; this is valid when full and when empty for the side being pushed.
  - The TX FIFO is popped on tx_valid & tx_ready. The RX FIFO is pushed on rx_valid & rx_ready.
  - An APB DATA write and a tx pop in the same cycle are both honoured.
  - An APB DATA pop and an rx push in the same cycle are both honoured. Fullness and emptiness are judged before the cycle's updates.
- rx_overflow: set when rx_valid=1 while CTRL.EN=1 and the RX FIFO is full (rx_ready=0).
- EN=0: tx_valid=0 and rx_ready=0. APB access to both FIFOs still works.
- irq = IRQ_EN & (rx_not_empty | rx_overflow), registered (one-cycle delay).
- Protocol misuse: PSEL dropping mid-access aborts the transfer. No FIFO side effects occur unless the completing cycle was reached.
- Reset mid-transfer: the transfer is abandoned, PREADY=0 and everything is cleared.

Test Plan:
- Reset, then read STATUS -> PRDATA=0x00000000, PREADY on the first access cycle, PSLVERR=0; irq=0, tx_valid=0.
- CTRL=0x1; write DATA 0xA5A50001..0xA5A50008; ninth write -> PSLVERR=1 and STATUS[31:24]=8. With tx_ready=1, the consumer receives exactly 0xA5A50001..08 in order, then tx_valid falls.
- CTRL=0x3; producer pushes 0x12345678 -> irq=1 two cycles later. DATA read takes one wait state and returns 0x12345678, PSLVERR=0. irq falls after the FIFO empties. A further DATA read -> PRDATA=0, PSLVERR=1.
- Fill the RX FIFO to 8 and hold rx_valid=1 -> rx_ready=0 and STATUS[3]=1. Write CTRL=0x7 -> both counts 0, STATUS=0, CTRL reads 0x3.
- Simultaneous events: with the TX FIFO full and tx_ready=1, an APB DATA write in the same cycle as a pop -> accepted, PSLVERR=0, count stays 8. Repeat across the pointer wrap and check order is preserved.
- Access to PADDR=0x0C and to 0x10, plus a write to 0x04 -> PSLVERR=1 each time, no register change; PSEL deasserted in the DATA read wait state -> no pop.
